// File: rtl/calc_mask_pkg.sv
// Shared types and width helpers for the multi-column mask calculator.
// Holds the FSM state encoding plus beat-size and span-width helpers.
package calc_mask_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int calc_lb(input int beat_bytes);
        return $clog2(beat_bytes);
    endfunction

    // Width of (lane + width - 1): wide enough that the beat count never truncates.
    function automatic int span_w(input int lb, input int colw);
        return ((lb > colw) ? lb : colw) + 2;
    endfunction

endpackage

// File: rtl/calc_mask_span.sv
// Combinational byte-span decoder: (byte address, width) -> beat address,
// first lane, last lane and number of beats touched.
module calc_mask_span
    import calc_mask_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int COLW_W     = 6,
    parameter int BEAT_BYTES = 16,
    localparam int LB        = calc_lb(BEAT_BYTES)
) (
    input  logic [ADDR_W-1:0]    byte_addr,
    input  logic [COLW_W-1:0]    width,
    output logic [ADDR_W-LB-1:0] beat_addr,
    output logic [LB-1:0]        start_lane,
    output logic [LB-1:0]        last_lane,
    output logic [COLW_W-1:0]    beats
);

    localparam int SW = span_w(LB, COLW_W);

    logic [SW-1:0] last_off;

    assign beat_addr  = byte_addr[ADDR_W-1:LB];
    assign start_lane = byte_addr[LB-1:0];
    assign last_off   = SW'(start_lane) + SW'(width) - SW'(1);
    assign last_lane  = last_off[LB-1:0];
    assign beats      = COLW_W'((last_off >> LB) + SW'(1));

endmodule

// File: rtl/calc_mask_multi.sv
// Walks rows x projected columns of a row-major table, issuing one read request
// and one packed write address per cell. Optional check: CALC_MASK_MULTI_ERR_CHK_EN.
module calc_mask_multi
    import calc_mask_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SIZE_W     = 16,
    parameter int COLW_W     = 6,
    parameter int BEAT_BYTES = 16,
    parameter int MAX_COLS   = 4,
    localparam int LB        = calc_lb(BEAT_BYTES),
    localparam int NW        = $clog2(MAX_COLS + 1),
    localparam int CW        = $clog2(MAX_COLS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [ADDR_W-1:0]          i_base_addr,
    input  logic [SIZE_W-1:0]          i_row_size,
    input  logic [SIZE_W-1:0]          i_row_cnt,
    input  logic [NW-1:0]              i_num_cols,
    input  logic [MAX_COLS*SIZE_W-1:0] i_col_offset,
    input  logic [MAX_COLS*COLW_W-1:0] i_col_width,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_req_valid,
    input  logic                       i_req_ready,
    output logic [ADDR_W-LB-1:0]       o_req_addr,
    output logic [COLW_W-1:0]          o_req_beats,
    output logic [LB-1:0]              o_req_start,
    output logic [LB-1:0]              o_req_end,
    output logic [CW-1:0]              o_req_col,
    output logic                       o_req_last,
    output logic [ADDR_W-1:0]          o_w_addr,
    output logic [COLW_W-1:0]          o_w_beats,
    output logic                       o_err
);

    state_e              state;
    logic [ADDR_W-1:0]   row_base;
    logic [SIZE_W-1:0]   row_size;
    logic [SIZE_W-1:0]   row_cnt;
    logic [SIZE_W-1:0]   row_idx;
    logic [NW-1:0]       num_cols;
    logic [SIZE_W-1:0]   col_off [MAX_COLS];
    logic [COLW_W-1:0]   col_wid [MAX_COLS];

    logic                hs;
    logic                col_last;
    logic                row_last;
    logic                empty_job;
    logic                cfg_bad;
    logic                adv;

    logic [CW-1:0]       nxt_col;
    logic [ADDR_W-1:0]   nxt_base;
    logic [ADDR_W-1:0]   nxt_waddr;
    logic [ADDR_W-1:0]   nxt_byte;
    logic [COLW_W-1:0]   nxt_wid;
    logic                nxt_last;

    logic [ADDR_W-LB-1:0] rd_addr;
    logic [LB-1:0]        rd_start;
    logic [LB-1:0]        rd_end;
    logic [COLW_W-1:0]    rd_beats;
    logic [ADDR_W-LB-1:0] wr_addr;
    logic [LB-1:0]        wr_start;
    logic [LB-1:0]        wr_end;
    logic [COLW_W-1:0]    wr_beats;
    logic                 unused_wr;

    assign hs        = o_req_valid && i_req_ready;
    assign col_last  = (NW'(o_req_col) + NW'(1)) == num_cols;
    assign row_last  = (row_idx + SIZE_W'(1)) == row_cnt;
    assign empty_job = (row_cnt == '0) || (num_cols == '0);
    assign adv       = (state == LOAD && !empty_job && !cfg_bad)
                    || (state == ISSUE && hs && !(col_last && row_last));

    // Next cell: LOAD seeds (row 0, col 0, w_addr 0); ISSUE steps from the current request.
    always_comb begin
        nxt_col   = '0;
        nxt_base  = row_base;
        nxt_waddr = '0;
        if (state == ISSUE) begin
            nxt_waddr = o_w_addr + ADDR_W'(col_wid[o_req_col]);
            if (col_last) begin
                nxt_base = row_base + ADDR_W'(row_size);
            end else begin
                nxt_col = o_req_col + CW'(1);
            end
        end
    end

    assign nxt_byte = nxt_base + ADDR_W'(col_off[nxt_col]);
    assign nxt_wid  = col_wid[nxt_col];
    assign nxt_last = (NW'(nxt_col) + NW'(1)) == num_cols;

    calc_mask_span #(
        .ADDR_W     (ADDR_W),
        .COLW_W     (COLW_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_rd_span (
        .byte_addr  (nxt_byte),
        .width      (nxt_wid),
        .beat_addr  (rd_addr),
        .start_lane (rd_start),
        .last_lane  (rd_end),
        .beats      (rd_beats)
    );

    calc_mask_span #(
        .ADDR_W     (ADDR_W),
        .COLW_W     (COLW_W),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_wr_span (
        .byte_addr  (nxt_waddr),
        .width      (nxt_wid),
        .beat_addr  (wr_addr),
        .start_lane (wr_start),
        .last_lane  (wr_end),
        .beats      (wr_beats)
    );

    // Only the beat count of the write span is needed; o_w_addr carries the address.
    assign unused_wr = ^{wr_addr, wr_start, wr_end};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_req_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (empty_job || cfg_bad) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state       <= ISSUE;
                        o_req_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs && col_last && row_last) begin
                        state       <= DONE;
                        o_req_valid <= 1'b0;
                        o_done      <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Config latch and request registers; request fields only move on adv.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_base    <= '0;
            row_size    <= '0;
            row_cnt     <= '0;
            row_idx     <= '0;
            num_cols    <= '0;
            o_req_addr  <= '0;
            o_req_beats <= '0;
            o_req_start <= '0;
            o_req_end   <= '0;
            o_req_col   <= '0;
            o_req_last  <= 1'b0;
            o_w_addr    <= '0;
            o_w_beats   <= '0;
            for (int c = 0; c < MAX_COLS; c++) begin
                col_off[c] <= '0;
                col_wid[c] <= '0;
            end
        end else begin
            if (state == IDLE && i_start) begin
                row_base <= i_base_addr;
                row_size <= i_row_size;
                row_cnt  <= i_row_cnt;
                num_cols <= i_num_cols;
                row_idx  <= '0;
                o_w_addr <= '0;
                for (int c = 0; c < MAX_COLS; c++) begin
                    col_off[c] <= i_col_offset[c*SIZE_W +: SIZE_W];
                    col_wid[c] <= i_col_width[c*COLW_W +: COLW_W];
                end
            end
            if (adv) begin
                o_req_addr  <= rd_addr;
                o_req_beats <= rd_beats;
                o_req_start <= rd_start;
                o_req_end   <= rd_end;
                o_req_col   <= nxt_col;
                o_req_last  <= nxt_last;
                o_w_addr    <= nxt_waddr;
                o_w_beats   <= wr_beats;
                row_base    <= nxt_base;
                if (state == ISSUE && col_last) begin
                    row_idx <= row_idx + SIZE_W'(1);
                end
            end
        end
    end

`ifdef CALC_MASK_MULTI_ERR_CHK_EN
    localparam int SW1 = SIZE_W + 1;

    // A used column must be non-empty and lie entirely within the row.
    always_comb begin
        cfg_bad = 1'b0;
        for (int c = 0; c < MAX_COLS; c++) begin
            if (NW'(c) < num_cols) begin
                if (col_wid[c] == '0 ||
                    (SW1'(col_off[c]) + SW1'(col_wid[c])) > SW1'(row_size)) begin
                    cfg_bad = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (state == IDLE && i_start) begin
            o_err <= 1'b0;
        end else if (state == LOAD && cfg_bad) begin
            o_err <= 1'b1;
        end
    end
`else
    assign cfg_bad = 1'b0;
    assign o_err   = 1'b0;
`endif

endmodule
